// File: rtl/fft_stream_pkg.sv
// Shared widths and reader FSM encoding for the filter-buffer to FFT stream path.
// The optional tuser sideband (FILBUF_RD_TUSER_EN) widens the skid FIFO via skid_width().
package fft_stream_pkg;

    localparam int FILBUF_ADDR_W = 14;
    localparam int FILBUF_DATA_W = 32;
    localparam int FILBUF_USER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Skid entry layout: {[user], last, data}
    function automatic int skid_width(input bit with_user);
        return FILBUF_DATA_W + 1 + (with_user ? FILBUF_USER_W : 0);
    endfunction

endpackage

// File: rtl/filbuf_rd_skid.sv
// Two-entry synchronous FIFO holding stream beats between the BRAM read port and AXI-Stream.
// The caller guarantees no write when full and no read when empty.
module filbuf_rd_skid #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_rd_en) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry only changes on a pop, so data stays stable across stalls.
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/filbuf_stream_reader.sv
// Streams a completed filter buffer (ROW_LEN x NUM_ROWS) out as AXI-Stream FFT frames.
// Define FILBUF_RD_TUSER_EN to add m_axis_tuser carrying the row index of each beat.
module filbuf_stream_reader
    import fft_stream_pkg::*;
#(
    parameter int ROW_LEN  = 128,
    parameter int NUM_ROWS = 128
) (
    input  logic                     s_axi_aclk,
    input  logic                     reset,
    input  logic                     stream_start,
    output logic                     busy,
    output logic                     done,
    output logic                     filbuf_rden,
    output logic [FILBUF_ADDR_W-1:0] filbuf_rdaddr,
    input  logic [FILBUF_DATA_W-1:0] filbuf_rddata,
    output logic [FILBUF_DATA_W-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
`ifdef FILBUF_RD_TUSER_EN
    ,
    output logic [FILBUF_USER_W-1:0] m_axis_tuser
`endif
);

    localparam int TOTAL = ROW_LEN * NUM_ROWS;
    localparam logic [FILBUF_ADDR_W-1:0] ADDR_LAST = FILBUF_ADDR_W'(TOTAL - 1);
    localparam logic [FILBUF_ADDR_W-1:0] COL_LAST  = FILBUF_ADDR_W'(ROW_LEN - 1);
`ifdef FILBUF_RD_TUSER_EN
    localparam int SKID_W = skid_width(1'b1);
`else
    localparam int SKID_W = skid_width(1'b0);
`endif

    rd_state_t              r_state;
    logic [FILBUF_ADDR_W-1:0] r_addr;
    logic [FILBUF_ADDR_W-1:0] r_col;
    logic                   r_pend;
    logic                   r_pend_last;
    logic                   r_done;
`ifdef FILBUF_RD_TUSER_EN
    logic [FILBUF_USER_W-1:0] r_row;
    logic [FILBUF_USER_W-1:0] r_pend_row;
`endif

    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_final;
    logic [1:0]        w_count;
    logic [SKID_W-1:0] w_wr_data;
    logic [SKID_W-1:0] w_rd_data;

    assign w_pop = (w_count != 2'd0) && m_axis_tready;

    // Issue is decided combinationally so the first beat reaches the FIFO head two cycles
    // after start. Credit check: occupancy + in-flight read + this read must fit after the pop.
    assign w_issue = !reset
                   && (((r_state == ST_IDLE) && stream_start) || (r_state == ST_READ))
                   && (({1'b0, w_count} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop}));
    assign w_issue_last = (r_addr == ADDR_LAST);

    // No reads are issued in DRAIN, so a pop of the sole remaining entry is the final beat.
    assign w_final = (r_state == ST_DRAIN) && w_pop && !r_pend && (w_count == 2'd1);

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_col       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_done      <= 1'b0;
`ifdef FILBUF_RD_TUSER_EN
            r_row       <= '0;
            r_pend_row  <= '0;
`endif
        end else begin
            r_done <= w_final;
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_last <= (r_col == COL_LAST);
`ifdef FILBUF_RD_TUSER_EN
                r_pend_row  <= r_row;
                if (w_issue_last) begin
                    r_row <= '0;
                end else if (r_col == COL_LAST) begin
                    r_row <= r_row + 8'd1;
                end
`endif
                if (w_issue_last || (r_col == COL_LAST)) begin
                    r_col <= '0;
                end else begin
                    r_col <= r_col + 14'd1;
                end
                r_addr <= w_issue_last ? '0 : r_addr + 14'd1;
            end
            case (r_state)
                ST_IDLE:  if (w_issue) r_state <= w_issue_last ? ST_DRAIN : ST_READ;
                ST_READ:  if (w_issue && w_issue_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_final) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FILBUF_RD_TUSER_EN
    assign w_wr_data = {r_pend_row, r_pend_last, filbuf_rddata};
`else
    assign w_wr_data = {r_pend_last, filbuf_rddata};
`endif

    filbuf_rd_skid #(
        .W(SKID_W)
    ) u_skid (
        .i_clk     (s_axi_aclk),
        .i_rst     (reset),
        .i_wr_en   (r_pend),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign filbuf_rden   = w_issue;
    assign filbuf_rdaddr = r_addr;
    assign m_axis_tvalid = (w_count != 2'd0);
    assign m_axis_tdata  = w_rd_data[FILBUF_DATA_W-1:0];
    assign m_axis_tlast  = m_axis_tvalid && w_rd_data[FILBUF_DATA_W];
`ifdef FILBUF_RD_TUSER_EN
    assign m_axis_tuser  = w_rd_data[SKID_W-1 -: FILBUF_USER_W];
`endif

endmodule

// File: tb/tb_filbuf_stream_reader.sv
// Directed bench for filbuf_stream_reader: full image, stalls with random tready,
// ignored restart, mid-stream reset abort. Checks tuser when FILBUF_RD_TUSER_EN is defined.
module tb_filbuf_stream_reader;

    localparam int ROW_LEN  = 128;
    localparam int NUM_ROWS = 128;
    localparam int TOTAL    = ROW_LEN * NUM_ROWS;

    logic        s_axi_aclk = 1'b0;
    logic        reset;
    logic        stream_start;
    logic        busy;
    logic        done;
    logic        filbuf_rden;
    logic [13:0] filbuf_rdaddr;
    logic [31:0] filbuf_rddata;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
`ifdef FILBUF_RD_TUSER_EN
    logic [7:0]  m_axis_tuser;
`endif

    logic [31:0] mem [TOTAL];

    int n_tests = 0;
    int n_fail  = 0;
    int mode;
    int cyc, exp_addr, reads, done_cnt, done_cyc, beat, first_valid, tlast_cnt;
    logic busy_c1, busy_at_done;

    filbuf_stream_reader #(
        .ROW_LEN  (ROW_LEN),
        .NUM_ROWS (NUM_ROWS)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .reset         (reset),
        .stream_start  (stream_start),
        .busy          (busy),
        .done          (done),
        .filbuf_rden   (filbuf_rden),
        .filbuf_rdaddr (filbuf_rdaddr),
        .filbuf_rddata (filbuf_rddata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef FILBUF_RD_TUSER_EN
        ,
        .m_axis_tuser  (m_axis_tuser)
`endif
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Filter-buffer BRAM model: data valid one cycle after rden.
    always @(posedge s_axi_aclk) begin
        if (filbuf_rden) filbuf_rddata <= mem[filbuf_rdaddr];
    end

    function automatic logic [31:0] pat(input int m, input int a);
        logic [15:0] lo;
        logic [15:0] hi;
        if (m == 0) return 32'(a);
        lo = 16'(a * 7 + 3);
        hi = ~16'(a);
        return {hi, lo};
    endfunction

    task automatic load_mem(input int m);
        mode = m;
        for (int i = 0; i < TOTAL; i++) mem[i] = pat(m, i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_book();
        cyc = -1; exp_addr = 0; reads = 0; done_cnt = 0; done_cyc = -1;
        beat = 0; first_valid = -1; tlast_cnt = 0;
        busy_c1 = 1'b0; busy_at_done = 1'b1;
    endtask

    // One clock: drive inputs at negedge, sample #1 later, score reads and beats.
    task automatic run_cycle(input logic start, input logic rdy);
        @(negedge s_axi_aclk);
        stream_start  = start;
        m_axis_tready = rdy;
        #1;
        if (!reset) begin
            cyc++;
            if (cyc == 1) busy_c1 = busy;
            if (filbuf_rden) begin
                check("rdaddr", 32'(filbuf_rdaddr), 32'(exp_addr));
                exp_addr++;
                reads++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (m_axis_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                if (beat >= TOTAL) begin
                    check("beat_overrun", 32'(beat), 32'(TOTAL - 1));
                end else begin
                    check($sformatf("tdata@%0d", beat), m_axis_tdata, pat(mode, beat));
                    check($sformatf("tlast@%0d", beat), 32'(m_axis_tlast),
                          32'((beat % ROW_LEN) == ROW_LEN - 1));
`ifdef FILBUF_RD_TUSER_EN
                    check($sformatf("tuser@%0d", beat), 32'(m_axis_tuser),
                          32'((beat / ROW_LEN) % 256));
`endif
                    if (m_axis_tready) begin
                        if (m_axis_tlast) tlast_cnt++;
                        beat++;
                    end
                end
            end
        end
    endtask

    initial begin
        bit sent2;
        reset = 1'b1;
        stream_start = 1'b0;
        m_axis_tready = 1'b1;
        load_mem(0);
        reset_book();

        // Reset values
        repeat (3) run_cycle(1'b0, 1'b1);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_rden",   32'(filbuf_rden), 32'd0);
        check("rst_rdaddr", 32'(filbuf_rdaddr), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast",  32'(m_axis_tlast), 32'd0);
        check("rst_tdata",  m_axis_tdata, 32'd0);

        // Run 1: start in the first cycle after reset, tready held high
        reset = 1'b0;
        reset_book();
        run_cycle(1'b1, 1'b1);
        check("r1_start_rden", 32'(filbuf_rden), 32'd1);
        while (done_cnt == 0 && cyc < 20000) run_cycle(1'b0, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b1);
        check("r1_first_valid", 32'(first_valid), 32'd2);
        check("r1_busy_c1",     32'(busy_c1), 32'd1);
        check("r1_beats",       32'(beat), 32'(TOTAL));
        check("r1_reads",       32'(reads), 32'(TOTAL));
        check("r1_tlast_cnt",   32'(tlast_cnt), 32'(NUM_ROWS));
        check("r1_done_cnt",    32'(done_cnt), 32'd1);
        check("r1_done_cyc",    32'(done_cyc), 32'(TOTAL + 2));
        check("r1_busy_at_done", 32'(busy_at_done), 32'd0);
        check("r1_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Run 2: 20 stalled cycles, then 50% tready with a stray start at beat 500
        load_mem(1);
        reset_book();
        run_cycle(1'b1, 1'b0);
        repeat (19) run_cycle(1'b0, 1'b0);
        check("r2_stall_reads",  32'(reads), 32'd2);
        check("r2_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("r2_stall_tdata",  m_axis_tdata, pat(1, 0));
        check("r2_stall_beat",   32'(beat), 32'd0);
        sent2 = 1'b0;
        while (done_cnt == 0 && cyc < 50000) begin
            if (beat == 500 && !sent2) begin
                sent2 = 1'b1;
                run_cycle(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                run_cycle(1'b0, 1'($urandom_range(0, 1)));
            end
        end
        repeat (4) run_cycle(1'b0, 1'b1);
        check("r2_beats",     32'(beat), 32'(TOTAL));
        check("r2_reads",     32'(reads), 32'(TOTAL));
        check("r2_tlast_cnt", 32'(tlast_cnt), 32'(NUM_ROWS));
        check("r2_done_cnt",  32'(done_cnt), 32'd1);
        check("r2_idle_busy", 32'(busy), 32'd0);

        // Run 3: reset at beat 1000, then restart from address 0
        load_mem(0);
        reset_book();
        run_cycle(1'b1, 1'b1);
        while (beat < 1000 && cyc < 2000) run_cycle(1'b0, 1'b1);
        check("r3_pre_beats", 32'(beat), 32'd1000);
        reset = 1'b1;
        run_cycle(1'b0, 1'b1);
        reset = 1'b0;
        reset_book();
        run_cycle(1'b1, 1'b1);
        check("r3_busy",   32'(busy), 32'd0);
        check("r3_done",   32'(done), 32'd0);
        check("r3_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("r3_tlast",  32'(m_axis_tlast), 32'd0);
        check("r3_tdata",  m_axis_tdata, 32'd0);
        check("r3_rden",   32'(filbuf_rden), 32'd1);
        check("r3_rdaddr", 32'(filbuf_rdaddr), 32'd0);
        while (done_cnt == 0 && cyc < 20000) run_cycle(1'b0, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b1);
        check("r3_beats",    32'(beat), 32'(TOTAL));
        check("r3_done_cnt", 32'(done_cnt), 32'd1);
        check("r3_done_cyc", 32'(done_cyc), 32'(TOTAL + 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
